// File: rtl/demux_stream_1to2.sv
// Registered 1-to-2 stream demultiplexer: each input word is steered by its
// select bit into one of two single-entry output slots, with per-output accept counters.
module demux_stream_1to2 #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          InValid,
  output logic          InReady,
  input  logic          InSel,
  input  logic [N-1:0]  InData,
  output logic          Out0Valid,
  input  logic          Out0Ready,
  output logic [N-1:0]  Out0Data,
  output logic          Out1Valid,
  input  logic          Out1Ready,
  output logic [N-1:0]  Out1Data,
  output logic [CW-1:0] Cnt0,
  output logic [CW-1:0] Cnt1
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e   state_q [2];
  slot_state_e   state_d [2];
  logic [N-1:0]  data_q  [2];
  logic [N-1:0]  data_d  [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];

  logic [1:0] out_ready;
  logic [1:0] drain;
  logic       slot_can_take;
  logic       accept;

  assign out_ready = {Out1Ready, Out0Ready};

  // A full slot that drains this cycle can be refilled on the same edge,
  // which is what gives one word per clock through a single output.
  always_comb begin
    // NOTE: every always_comb target gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    drain         = 2'b00;
    slot_can_take = 1'b0;
    accept        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    for (int i = 0; i < 2; i++) begin
      drain[i] = (state_q[i] == SLOT_FULL) && out_ready[i];
    end

    slot_can_take = (state_q[InSel] == SLOT_EMPTY) || out_ready[InSel];
    accept        = InValid && ResetN && slot_can_take;

    for (int i = 0; i < 2; i++) begin
      if (accept && (InSel == 1'(i))) begin
        state_d[i] = SLOT_FULL;
        data_d[i]  = InData;
        cnt_d[i]   = cnt_q[i] + CW'(1);
      end else if (drain[i]) begin
        state_d[i] = SLOT_EMPTY;
      end
    end
  end

  // Gated by ResetN so the producer sees not-ready while reset is held.
  assign InReady = ResetN && slot_can_take;

  // NOTE: the data holding registers are reset too, because the block must
  // present all-zero outputs during reset rather than stale words.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= SLOT_EMPTY;
        data_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other, independent of statement order.
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign Out0Valid = (state_q[0] == SLOT_FULL);
  assign Out1Valid = (state_q[1] == SLOT_FULL);
  assign Out0Data  = data_q[0];
  assign Out1Data  = data_q[1];
  assign Cnt0      = cnt_q[0];
  assign Cnt1      = cnt_q[1];

endmodule

// File: tb/tb_demux_stream_1to2.sv
// Self-checking bench for demux_stream_1to2: directed scenarios followed by
// random traffic, all compared against a slot-level behavioural model.
module tb_demux_stream_1to2;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          Clk;
  logic          ResetN;
  logic          InValid;
  logic          InReady;
  logic          InSel;
  logic [N-1:0]  InData;
  logic          Out0Valid;
  logic          Out0Ready;
  logic [N-1:0]  Out0Data;
  logic          Out1Valid;
  logic          Out1Ready;
  logic [N-1:0]  Out1Data;
  logic [CW-1:0] Cnt0;
  logic [CW-1:0] Cnt1;

  demux_stream_1to2 #(.N(N), .CW(CW)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .InValid   (InValid),
    .InReady   (InReady),
    .InSel     (InSel),
    .InData    (InData),
    .Out0Valid (Out0Valid),
    .Out0Ready (Out0Ready),
    .Out0Data  (Out0Data),
    .Out1Valid (Out1Valid),
    .Out1Ready (Out1Ready),
    .Out1Data  (Out1Data),
    .Cnt0      (Cnt0),
    .Cnt1      (Cnt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Model: each output is a box that either holds one word or is empty,
  // and each counter is the number of words ever delivered into that box.
  bit mdl_full [2];
  int mdl_word [2];
  int mdl_count[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mdl_full[i]  = 1'b0;
      mdl_word[i]  = 0;
      mdl_count[i] = 0;
    end
  endtask

  function automatic bit model_ready(input bit sel, input bit r0, input bit r1);
    bit r;
    r = sel ? r1 : r0;
    return !mdl_full[sel] || r;
  endfunction

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_edge(input bit v, input bit sel, input int d, input bit r0, input bit r1);
    bit take;
    bit rdy[2];
    rdy[0] = r0;
    rdy[1] = r1;
    take = v && model_ready(sel, r0, r1);
    for (int i = 0; i < 2; i++) begin
      if (take && (int'(sel) == i)) begin
        mdl_full[i]  = 1'b1;
        mdl_word[i]  = d;
        mdl_count[i] = (mdl_count[i] + 1) % (1 << CW);
      end else if (mdl_full[i] && rdy[i]) begin
        mdl_full[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".v0"}, 32'(Out0Valid), 32'(mdl_full[0]));
    check({tag, ".v1"}, 32'(Out1Valid), 32'(mdl_full[1]));
    check({tag, ".d0"}, 32'(Out0Data),  32'(mdl_word[0]));
    check({tag, ".d1"}, 32'(Out1Data),  32'(mdl_word[1]));
    check({tag, ".c0"}, 32'(Cnt0),      32'(mdl_count[0]));
    check({tag, ".c1"}, 32'(Cnt1),      32'(mdl_count[1]));
  endtask

  // One clock cycle; called just after a rising edge, returns just after the next.
  task automatic step(input string tag, input bit v, input bit sel, input logic [N-1:0] d,
                      input bit r0, input bit r1);
    InValid   = v;
    InSel     = sel;
    InData    = d;
    Out0Ready = r0;
    Out1Ready = r1;
    #1;
    check({tag, ".rdy"}, 32'(InReady), 32'(model_ready(sel, r0, r1)));
    model_edge(v, sel, int'(d), r0, r1);
    @(posedge Clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    ResetN  = 1'b0;
    InValid = 1'b0;
    model_clear();
    #1;
    check_outputs("rst_hold");
    check("rst_hold.rdy", 32'(InReady), 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    ResetN    = 1'b0;
    InValid   = 1'b1;
    InSel     = 1'b0;
    InData    = 8'hFF;
    Out0Ready = 1'b1;
    Out1Ready = 1'b1;
    model_clear();

    // Reset held with a word offered: nothing is taken, everything is zero.
    #3;
    check("reset.rdy", 32'(InReady), 32'd0);
    check_outputs("reset");
    repeat (2) @(posedge Clk);
    #1;
    check("reset_edges.rdy", 32'(InReady), 32'd0);
    check_outputs("reset_edges");

    // Release at a falling edge; the very next rising edge accepts.
    @(negedge Clk);
    InData    = 8'h5A;
    Out0Ready = 1'b0;
    ResetN    = 1'b1;
    #1;
    check("release.rdy", 32'(InReady), 32'd1);
    model_edge(1'b1, 1'b0, 'h5A, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    check_outputs("first_accept");
    step("drain_first", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Routing by select bit.
    apply_reset();
    step("route_a5", 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    check("route_a5.data", 32'(Out0Data), 32'h0A5);
    step("route_3c", 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    check("route_3c.data", 32'(Out1Data), 32'h03C);
    check("route.cnt0", 32'(Cnt0), 32'd1);
    check("route.cnt1", 32'(Cnt1), 32'd1);
    step("route_idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Backpressure on output 0, then re-steer the stalled word to output 1.
    step("bp_11", 1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    step("bp_22_stall", 1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
    check("bp.held", 32'(Out0Data), 32'h011);
    check("bp.held_v", 32'(Out0Valid), 32'd1);
    step("bp_22_resteer", 1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    check("bp.resteer", 32'(Out1Data), 32'h022);
    step("bp_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Full-rate stream into output 1 and counter wrap.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step("thru", 1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      check("thru.data", 32'(Out1Data), 32'(i));
    end
    check("thru.wrap", 32'(Cnt1), 32'd0);
    step("thru_idle", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

    // Both slots full and draining while a new word refills slot 0.
    step("conc_fill0", 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    step("conc_fill1", 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    step("conc", 1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    check("conc.v1", 32'(Out1Valid), 32'd0);
    check("conc.d0", 32'(Out0Data), 32'h077);

    // Asynchronous reset mid-cycle with both slots full.
    step("mid_fill1", 1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
    InValid = 1'b0;
    #2;
    ResetN = 1'b0;
    model_clear();
    #1;
    check_outputs("mid_rst");
    check("mid_rst.rdy", 32'(InReady), 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
    check_outputs("mid_rst_after");

    // Random traffic, including stalls, concurrent drains and select changes.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
